// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle fetch/execute controller.
package mc_pkg;

    typedef enum logic [2:0] {
        FETCH_REQ  = 3'd0,
        FETCH_WAIT = 3'd1,
        EXEC       = 3'd2,
        MEM_REQ    = 3'd3,
        MEM_WAIT   = 3'd4,
        WB         = 3'd5,
        HALT       = 3'd6,
        ERR        = 3'd7
    } state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;
    localparam int          TIMER_W          = 16;

    // States in which the controller is stalled on a bus handshake.
    function automatic logic is_bus_wait(input state_e s);
        return (s == FETCH_REQ) || (s == FETCH_WAIT) || (s == MEM_REQ) || (s == MEM_WAIT);
    endfunction

endpackage

// File: rtl/bus_timer.sv
// Handshake watchdog: counts cycles spent in one waiting state, flags expiry at TIMEOUT.
module bus_timer
    import mc_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    // The counter starts at zero on the first waiting cycle, so TIMEOUT-1 marks the last one.
    localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(TIMEOUT - 1);

    logic [TIMER_W-1:0] cnt_q;
    logic [TIMER_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + TIMER_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i && (cnt_q == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: fetch, execute, optional memory access, writeback,
// with handshake watchdog, sticky halt/error states and a retired-instruction counter.
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter int          XLEN     = 64,
    parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          TIMEOUT  = 255,
    parameter int          CNT_W    = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_resp_valid,
    input  logic [31:0]      imem_resp_data,
    output logic             dmem_req_valid,
    input  logic             dmem_req_ready,
    input  logic             dmem_resp_valid,
    input  logic             dec_mem,
    input  logic             dec_halt,
    input  logic [XLEN-1:0]  pc_next,
    output logic [XLEN-1:0]  pc,
    output logic [31:0]      instr,
    output logic             commit,
    output logic             halted,
    output logic             bus_err,
    output logic [CNT_W-1:0] retired,
    output logic             rd_wr
);

    localparam logic [XLEN-1:0] RST_PC     = RESET_PC[XLEN-1:0];
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              tmr_expired;

    bus_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_bus_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (state_d != state_q),
        .en_i      (is_bus_wait(state_q)),
        .expired_o (tmr_expired)
    );

    // A completing handshake is tested before the watchdog so it wins on the expiry cycle.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;
        case (state_q)
            FETCH_REQ: begin
                if (imem_req_ready)   state_d = FETCH_WAIT;
                else if (tmr_expired) state_d = ERR;
            end
            FETCH_WAIT: begin
                if (imem_resp_valid) begin
                    instr_d = imem_resp_data;
                    state_d = EXEC;
                end else if (tmr_expired) begin
                    state_d = ERR;
                end
            end
            EXEC: begin
                if (dec_halt)     state_d = HALT;
                else if (dec_mem) state_d = MEM_REQ;
                else              state_d = WB;
            end
            MEM_REQ: begin
                if (dmem_req_ready)   state_d = MEM_WAIT;
                else if (tmr_expired) state_d = ERR;
            end
            MEM_WAIT: begin
                if (dmem_resp_valid)  state_d = WB;
                else if (tmr_expired) state_d = ERR;
            end
            WB: begin
                pc_d      = pc_next & ALIGN_MASK;
                retired_d = retired_q + CNT_W'(1);
                state_d   = FETCH_REQ;
            end
            HALT:    state_d = HALT;
            ERR:     state_d = ERR;
            default: state_d = ERR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH_REQ;
            pc_q      <= RST_PC;
            instr_q   <= NOP_INSTR;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
        end
    end

    // Reset parks the FSM in FETCH_REQ; the request is masked until rst_n releases.
    assign imem_req_valid = rst_n && (state_q == FETCH_REQ);
    assign imem_addr      = pc_q;
    assign dmem_req_valid = (state_q == MEM_REQ);
    assign rd_wr          = dmem_req_valid;
    assign commit         = (state_q == WB);
    assign halted         = (state_q == HALT);
    assign bus_err        = (state_q == ERR);
    assign pc             = pc_q;
    assign instr          = instr_q;
    assign retired        = retired_q;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter XLEN, default 64, datapath/PC width (32 or 64).
REQ-002 Parameter RESET_PC, default 64'h8000_0000 truncated to XLEN, first fetch address.
REQ-003 Parameter TIMEOUT, default 255, max cycles waiting on any bus handshake (1..65535).
REQ-004 Parameter CNT_W, default 64, retired-instruction counter width.
REQ-005 Ports: clk  in  1  clock; one clock, all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 imem_req_valid out 1 fetch request; imem_req_ready in 1; imem_addr out XLEN (=pc).
REQ-008 imem_resp_valid in 1; imem_resp_data in 32 fetched instruction.
REQ-009 dmem_req_valid out 1; dmem_req_ready in 1; dmem_resp_valid in 1 load data / store ack.
REQ-010 dec_mem in 1 decoded load-or-store; dec_halt in 1 decoded ebreak (both valid in EXEC).
REQ-011 pc_next in XLEN next PC computed externally from instr.
REQ-012 pc out XLEN; instr out 32 latched instruction; commit out 1 writeback pulse (gates RegWrite/CSR write).
REQ-013 halted out 1; bus_err out 1; retired out CNT_W; rd_wr out 1 (=dmem_req_valid).

Function
REQ-014 FSM states: FETCH_REQ, FETCH_WAIT, EXEC, MEM_REQ, MEM_WAIT, WB, HALT, ERR.
REQ-015 FETCH_REQ: imem_req_valid=1, imem_addr=pc; on imem_req_ready -> FETCH_WAIT.
REQ-016 FETCH_WAIT: on imem_resp_valid latch instr<=imem_resp_data -> EXEC; imem_resp_valid outside FETCH_WAIT ignored.
REQ-017 EXEC (exactly 1 cycle): dec_halt -> HALT (priority); else dec_mem -> MEM_REQ; else -> WB.
REQ-018 MEM_REQ: dmem_req_valid=1 held until dmem_req_ready -> MEM_WAIT; MEM_WAIT: on dmem_resp_valid -> WB.
REQ-019 WB (1 cycle): commit=1, pc<=pc_next, retired<=retired+1 (wraps modulo 2^CNT_W) -> FETCH_REQ.
REQ-020 Minimum latency non-memory instruction with same-cycle ready/resp: 4 cycles; memory instruction: 6 cycles.
REQ-021 Valid signals, once asserted, stay high until ready; addr stable while valid.
REQ-022 Timeout counter resets on every state change; in FETCH_REQ/FETCH_WAIT/MEM_REQ/MEM_WAIT reaching TIMEOUT cycles without exit -> ERR.
REQ-023 Handshake completing on the same cycle the counter reaches TIMEOUT wins (normal transition, no error).
REQ-024 ERR: bus_err=1, all req_valid=0, commit=0; sticky until reset.
REQ-025 HALT: halted=1, no requests, pc/instr/retired frozen; sticky until reset; ebreak not counted in retired.
REQ-026 pc_next bits [1:0] forced to 0 on load into pc.

Reset
REQ-027 rst_n low asynchronously: state=FETCH_REQ, pc=RESET_PC, instr=32'h0000_0013, retired=0, timer=0.
REQ-028 During reset all outputs low except pc/imem_addr=RESET_PC, instr=NOP; first request on first edge after deassert.
REQ-029 Reset mid-transaction abandons it; late responses arriving in FETCH_REQ after reset ignored.

Structure
REQ-030 Shared package mc_pkg: state enum (3 bits), NOP_INSTR constant, default RESET_PC.
REQ-031 One sub-module bus_timer (counter, clear, expire at TIMEOUT); FSM, PC and counters in multicycle_ctrl.

Verification
REQ-032 addi stream, ready/resp immediate: pc 8000_0000,..04,..08 each 4 cycles; retired=3 after 12 cycles post-reset.
REQ-033 Load with dmem_req_ready delayed 3 cycles: dmem_req_valid held 4 cycles, commit once, instruction total 9 cycles.
REQ-034 imem_resp_valid never returns, TIMEOUT=8: ERR entered 8 cycles into FETCH_WAIT, bus_err=1, no further requests.
REQ-035 ebreak fetched: HALT after EXEC, halted=1, commit never pulses, retired unchanged.
REQ-036 rst_n pulsed low during MEM_WAIT: pc=RESET_PC, retired=0 same cycle; stale dmem_resp_valid causes no commit.
REQ-037 XLEN=32, CNT_W=4: 17 instructions -> retired=1 (wrap), pc_next=32'h0000_0103 loads pc=32'h0000_0100.
